// File: rtl/switch_inport_pkg.sv
// Shared types and constants for the switch/button INPORT capture path.
package switch_inport_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int INPORT_WIDTH            = 32;

  typedef enum logic [1:0] {
    KEY_RELEASED     = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_PRESSED      = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_e;

endpackage

// File: rtl/level_debouncer.sv
// Two-flop synchronizer plus a shared stability counter: a new level is accepted only after it
// has been seen unchanged for DEBOUNCE_CYCLES consecutive clocks.
module level_debouncer
  import switch_inport_pkg::*;
#(
  parameter int               WIDTH           = 1,
  parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int               CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_stable,
  output logic             o_load
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_sync_q;
  logic [WIDTH-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt;

  logic w_differs;
  logic w_restart;
  logic w_load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= RESET_VAL;
      r_sync   <= RESET_VAL;
      r_sync_q <= RESET_VAL;
    end else begin
      r_meta   <= i_raw;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
    end
  end

  // A change of the synchronized value while already counting means it is still bouncing.
  always_comb begin
    w_differs = (r_sync != r_stable);
    w_restart = (r_cnt != '0) && (r_sync != r_sync_q);
    w_load    = w_differs && !w_restart && (r_cnt == LP_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_stable <= RESET_VAL;
    end else if (!w_differs) begin
      r_cnt <= '0;
    end else if (w_restart) begin
      r_cnt <= CNT_W'(1);
    end else if (w_load) begin
      r_cnt    <= '0;
      r_stable <= r_sync;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sync   = r_sync;
  assign o_stable = r_stable;
  assign o_load   = w_load;

endmodule

// File: rtl/switch_inport_capture.sv
// Board switch/enter-key front end for the CPU INPORT: one handshaken 32-bit word per key press.
// Define INPORT_AUTO_CAPTURE_EN to also capture on every debounced switch change.
module switch_inport_capture
  import switch_inport_pkg::*;
#(
  parameter int SW_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic [SW_WIDTH-1:0]     sw_raw,
  input  logic                    key_raw,
  input  logic                    rd_ack,
  output logic [INPORT_WIDTH-1:0] inport_data,
  output logic                    inport_valid,
  output logic                    overrun,
  output logic [SW_WIDTH-1:0]     sw_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SW_WIDTH-1:0]     w_sw_sync;
  logic                    w_sw_load;
  logic                    w_key_sync;
  logic                    w_key_stable;
  logic                    w_key_load;
  logic                    w_press;
  logic                    w_capture;
  logic [SW_WIDTH-1:0]     w_capture_sw;
  logic [INPORT_WIDTH-1:0] w_capture_word;

  key_state_e r_key_state;
  key_state_e w_key_state_nxt;

  logic [INPORT_WIDTH-1:0] r_data;
  logic                    r_valid;
  logic                    r_overrun;

  level_debouncer #(
    .WIDTH          (SW_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .RESET_VAL      ('0)
  ) u_sw_debounce (
    .i_clk   (CLOCK_50),
    .i_rst_n (reset_n),
    .i_raw   (sw_raw),
    .o_sync  (w_sw_sync),
    .o_stable(sw_stable),
    .o_load  (w_sw_load)
  );

  // The key idles high (released), so its synchronizer and stable level reset to 1.
  level_debouncer #(
    .WIDTH          (1),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .RESET_VAL      (1'b1)
  ) u_key_debounce (
    .i_clk   (CLOCK_50),
    .i_rst_n (reset_n),
    .i_raw   (key_raw),
    .o_sync  (w_key_sync),
    .o_stable(w_key_stable),
    .o_load  (w_key_load)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_key_state <= KEY_RELEASED;
    end else begin
      r_key_state <= w_key_state_nxt;
    end
  end

  // Press events come only from PRESS_WAIT, so a held key or release bounce never re-fires.
  always_comb begin
    w_key_state_nxt = r_key_state;
    w_press         = 1'b0;
    case (r_key_state)
      KEY_RELEASED: begin
        if (!w_key_sync) w_key_state_nxt = KEY_PRESS_WAIT;
      end
      KEY_PRESS_WAIT: begin
        if (w_key_load && w_key_stable) begin
          w_key_state_nxt = KEY_PRESSED;
          w_press         = 1'b1;
        end else if (w_key_sync) begin
          w_key_state_nxt = KEY_RELEASED;
        end
      end
      KEY_PRESSED: begin
        if (w_key_sync) w_key_state_nxt = KEY_RELEASE_WAIT;
      end
      KEY_RELEASE_WAIT: begin
        if (w_key_load && !w_key_stable) begin
          w_key_state_nxt = KEY_RELEASED;
        end else if (!w_key_sync) begin
          w_key_state_nxt = KEY_PRESSED;
        end
      end
      default: w_key_state_nxt = KEY_RELEASED;
    endcase
  end

`ifdef INPORT_AUTO_CAPTURE_EN
  // A switch update captures the value being loaded this edge, not the old stable value.
  assign w_capture    = w_press | w_sw_load;
  assign w_capture_sw = w_sw_load ? w_sw_sync : sw_stable;
`else
  logic w_unused_sw;
  assign w_unused_sw  = w_sw_load ^ (^w_sw_sync);
  assign w_capture    = w_press;
  assign w_capture_sw = sw_stable;
`endif

  always_comb begin
    w_capture_word                 = '0;
    w_capture_word[SW_WIDTH-1:0]   = w_capture_sw;
  end

  // A same-cycle rd_ack means the old word was consumed, so that capture is not an overrun.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_capture) begin
      r_data  <= w_capture_word;
      r_valid <= 1'b1;
      if (r_valid && !rd_ack) r_overrun <= 1'b1;
    end else if (rd_ack && r_valid) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign inport_data  = r_data;
  assign inport_valid = r_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_switch_inport_capture.sv
// Self-checking bench for switch_inport_capture with a 4-cycle debounce window; captured words
// are matched against a queue of expected words filled as each press is driven.
module tb_switch_inport_capture;

  localparam int SW_W = 8;
  localparam int DB   = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [SW_W-1:0] sw_raw;
  logic            key_raw;
  logic            rd_ack;
  logic [31:0]     inport_data;
  logic            inport_valid;
  logic            overrun;
  logic [SW_W-1:0] sw_stable;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic        prev_valid = 1'b0;
  logic [31:0] prev_data  = '0;

  always #5 clk = ~clk;

  switch_inport_capture #(
    .SW_WIDTH       (SW_W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .sw_raw      (sw_raw),
    .key_raw     (key_raw),
    .rd_ack      (rd_ack),
    .inport_data (inport_data),
    .inport_valid(inport_valid),
    .overrun     (overrun),
    .sw_stable   (sw_stable)
  );

  // A new word is visible as a valid rise or a data change while valid is held.
  always @(negedge clk) begin
    if (inport_valid && (!prev_valid || inport_data != prev_data)) obs_q.push_back(inport_data);
    prev_valid = inport_valid;
    prev_data  = inport_data;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_switches(input logic [SW_W-1:0] v);
    sw_raw = v;
    tick(8);
  endtask

  task automatic press_key(input int hold);
    key_raw = 1'b0;
    tick(hold);
    key_raw = 1'b1;
    tick(10);
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  task automatic wait_capture(output bit got, output logic [31:0] word);
    got  = 1'b0;
    word = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (obs_q.size() > 0) begin
        word = obs_q.pop_front();
        got  = 1'b1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic test_power_on_reset();
    reset_n = 1'b0;
    sw_raw  = '0;
    key_raw = 1'b1;
    rd_ack  = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    n_compared++;
    if (inport_data !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL por_data: got %h, expected %h", inport_data, 32'h0);
    end
    n_compared++;
    if (inport_valid !== 1'b0 || overrun !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL por_flags: got valid=%b overrun=%b, expected 0/0", inport_valid, overrun);
    end
    n_compared++;
    if (sw_stable !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL por_sw_stable: got %h, expected 00", sw_stable);
    end
  endtask

  task automatic test_switch_debounce();
    int bad_cycles;
    sw_raw = 8'hC0;
    tick(5);
    n_compared++;
    if (sw_stable !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL sw_latency_early: got %h after 5 clocks, expected 00", sw_stable);
    end
    tick(1);
    n_compared++;
    if (sw_stable !== 8'hC0) begin
      n_mismatched++;
      $display("[TB] FAIL sw_latency: got %h after 6 clocks, expected c0", sw_stable);
    end
    bad_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      sw_raw = (i % 2 == 0) ? 8'h00 : 8'hC0;
      tick(1);
      if (sw_stable !== 8'hC0) bad_cycles++;
      tick(1);
      if (sw_stable !== 8'hC0) bad_cycles++;
    end
    sw_raw = 8'hC0;
    tick(8);
    n_compared++;
    if (bad_cycles != 0 || sw_stable !== 8'hC0) begin
      n_mismatched++;
      $display("[TB] FAIL sw_bounce: %0d cycles off, final %h, expected 0 cycles and c0", bad_cycles, sw_stable);
    end
  endtask

  task automatic test_capture();
    bit got;
    logic [31:0] obs, exp_w;
    exp_q.push_back({24'h0, 8'hC0});
    key_raw = 1'b0;
    tick(10);
    wait_capture(got, obs);
    exp_w = exp_q.pop_front();
    n_compared++;
    if (!got || obs !== exp_w) begin
      n_mismatched++;
      $display("[TB] FAIL capture_word: got %h (seen=%b), expected %h", obs, got, exp_w);
    end
    pulse_ack();
    n_compared++;
    if (inport_valid !== 1'b0 || inport_data !== 32'h0000_00C0) begin
      n_mismatched++;
      $display("[TB] FAIL capture_ack: got valid=%b data=%h, expected 0/000000c0", inport_valid, inport_data);
    end
    tick(50);
    key_raw = 1'b1;
    n_compared++;
    if (inport_valid !== 1'b0 || obs_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL capture_hold: got valid=%b extra=%0d, expected no repeat", inport_valid, obs_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      key_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick(1);
    end
    key_raw = 1'b1;
    tick(10);
    for (int i = 0; i < 3; i++) begin
      key_raw = 1'b0;
      tick(1);
      key_raw = 1'b1;
      tick(3);
    end
    tick(10);
    n_compared++;
    if (inport_valid !== 1'b0 || obs_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL capture_glitch: got valid=%b extra=%0d, expected no capture", inport_valid, obs_q.size());
    end
  endtask

  task automatic test_handshake();
    bit got;
    logic [31:0] obs, exp_w;
    set_switches(8'h5A);
    exp_q.push_back({24'h0, 8'h5A});
    press_key(10);
    wait_capture(got, obs);
    exp_w = exp_q.pop_front();
    n_compared++;
    if (!got || obs !== exp_w) begin
      n_mismatched++;
      $display("[TB] FAIL hs_word: got %h (seen=%b), expected %h", obs, got, exp_w);
    end
    pulse_ack();
    n_compared++;
    if (inport_valid !== 1'b0 || inport_data !== 32'h0000_005A || overrun !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL hs_ack: got valid=%b data=%h ovr=%b, expected 0/0000005a/0", inport_valid, inport_data, overrun);
    end
    set_switches(8'h33);
    exp_q.push_back({24'h0, 8'h33});
    press_key(10);
    wait_capture(got, obs);
    exp_w = exp_q.pop_front();
    n_compared++;
    if (!got || obs !== exp_w) begin
      n_mismatched++;
      $display("[TB] FAIL hs_word2: got %h (seen=%b), expected %h", obs, got, exp_w);
    end
    set_switches(8'h66);
    exp_q.push_back({24'h0, 8'h66});
    key_raw = 1'b0;
    tick(5);
    n_compared++;
    if (inport_valid !== 1'b1 || inport_data !== 32'h0000_0033) begin
      n_mismatched++;
      $display("[TB] FAIL hs_pre_coincide: got valid=%b data=%h, expected 1/00000033", inport_valid, inport_data);
    end
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    n_compared++;
    if (inport_valid !== 1'b1 || inport_data !== 32'h0000_0066 || overrun !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL hs_coincide: got valid=%b data=%h ovr=%b, expected 1/00000066/0", inport_valid, inport_data, overrun);
    end
    tick(3);
    key_raw = 1'b1;
    tick(10);
    wait_capture(got, obs);
    exp_w = exp_q.pop_front();
    n_compared++;
    if (!got || obs !== exp_w) begin
      n_mismatched++;
      $display("[TB] FAIL hs_word3: got %h (seen=%b), expected %h", obs, got, exp_w);
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    bit got;
    logic [31:0] obs, exp_w;
    set_switches(8'h12);
    exp_q.push_back({24'h0, 8'h12});
    press_key(10);
    wait_capture(got, obs);
    exp_w = exp_q.pop_front();
    n_compared++;
    if (!got || obs !== exp_w || overrun !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ovr_first: got %h (seen=%b) ovr=%b, expected %h ovr=0", obs, got, overrun, exp_w);
    end
    set_switches(8'h34);
    exp_q.push_back({24'h0, 8'h34});
    press_key(10);
    wait_capture(got, obs);
    exp_w = exp_q.pop_front();
    n_compared++;
    if (!got || obs !== exp_w) begin
      n_mismatched++;
      $display("[TB] FAIL ovr_second: got %h (seen=%b), expected %h", obs, got, exp_w);
    end
    n_compared++;
    if (overrun !== 1'b1 || inport_valid !== 1'b1 || inport_data !== 32'h0000_0034) begin
      n_mismatched++;
      $display("[TB] FAIL ovr_flag: got ovr=%b valid=%b data=%h, expected 1/1/00000034", overrun, inport_valid, inport_data);
    end
    pulse_ack();
    n_compared++;
    if (inport_valid !== 1'b0 || overrun !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ovr_clear: got valid=%b ovr=%b, expected 0/0", inport_valid, overrun);
    end
  endtask

  task automatic test_auto_capture();
`ifdef INPORT_AUTO_CAPTURE_EN
    bit got;
    logic [31:0] obs, exp_w;
    exp_q.push_back({24'h0, 8'h05});
    set_switches(8'h05);
    wait_capture(got, obs);
    exp_w = exp_q.pop_front();
    n_compared++;
    if (!got || obs !== exp_w) begin
      n_mismatched++;
      $display("[TB] FAIL auto_first: got %h (seen=%b), expected %h", obs, got, exp_w);
    end
    pulse_ack();
    exp_q.push_back({24'h0, 8'h0A});
    sw_raw = 8'h0A;
    tick(6);
    n_compared++;
    if (inport_valid !== 1'b1 || inport_data !== 32'h0000_000A) begin
      n_mismatched++;
      $display("[TB] FAIL auto_capture: got valid=%b data=%h, expected 1/0000000a", inport_valid, inport_data);
    end
    wait_capture(got, obs);
    exp_w = exp_q.pop_front();
    n_compared++;
    if (!got || obs !== exp_w) begin
      n_mismatched++;
      $display("[TB] FAIL auto_word: got %h (seen=%b), expected %h", obs, got, exp_w);
    end
    pulse_ack();
`else
    set_switches(8'h05);
    sw_raw = 8'h0A;
    tick(6);
    n_compared++;
    if (sw_stable !== 8'h0A || inport_valid !== 1'b0 || inport_data !== 32'h0000_0034) begin
      n_mismatched++;
      $display("[TB] FAIL auto_off: got sw=%h valid=%b data=%h, expected 0a/0/00000034", sw_stable, inport_valid, inport_data);
    end
    tick(10);
    n_compared++;
    if (obs_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL auto_off_quiet: got %0d captures, expected 0", obs_q.size());
    end
`endif
  endtask

  task automatic test_async_reset();
    bit got;
    logic [31:0] obs, exp_w;
    set_switches(8'h77);
    exp_q.push_back({24'h0, 8'h77});
    press_key(10);
    wait_capture(got, obs);
    exp_w = exp_q.pop_front();
    set_switches(8'h21);
    exp_q.push_back({24'h0, 8'h21});
    press_key(10);
    wait_capture(got, obs);
    exp_w = exp_q.pop_front();
    n_compared++;
    if (!got || obs !== exp_w || overrun !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL rst_setup: got %h (seen=%b) ovr=%b, expected %h ovr=1", obs, got, overrun, exp_w);
    end
    key_raw = 1'b0;
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    n_compared++;
    if (inport_data !== 32'h0 || inport_valid !== 1'b0 || overrun !== 1'b0 || sw_stable !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL rst_async: got data=%h valid=%b ovr=%b sw=%h, expected all zero", inport_data, inport_valid, overrun, sw_stable);
    end
    key_raw = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(20);
    n_compared++;
    if (inport_valid !== 1'b0 || obs_q.size() != 0 || sw_stable !== 8'h21) begin
      n_mismatched++;
      $display("[TB] FAIL rst_recover: got valid=%b captures=%0d sw=%h, expected 0/0/21", inport_valid, obs_q.size(), sw_stable);
    end
    exp_q.push_back({24'h0, 8'h21});
    press_key(10);
    wait_capture(got, obs);
    exp_w = exp_q.pop_front();
    n_compared++;
    if (!got || obs !== exp_w || overrun !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_press: got %h (seen=%b) ovr=%b, expected %h ovr=0", obs, got, overrun, exp_w);
    end
  endtask

  initial begin
    test_power_on_reset();
    test_switch_debounce();
    test_capture();
    test_handshake();
    test_overrun();
    test_auto_capture();
    test_async_reset();
    tick(5);
    n_compared++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d expected / %0d observed left, expected 0/0", exp_q.size(), obs_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
